stack_frame_sequencer: RTL and testbench
========================================

# stack_frame_sequencer

Multi-cycle controller sequencing all stack traffic of the memory stage through the single 16-bit data-memory port. It accepts one stack operation per request (PUSH, POP, CALL, RET, INT, RTI) from the EM buffer and splits it into word-sized memory accesses. It maintains the stack pointer and stalls the pipeline while busy. It returns popped data, PC and flags to the write-back path and the fetch PC mux.

## Interface
Parameters:
- `DATA_W`, 16: memory word width.
- `SP_INIT`, 16'h07FF: SP reset value; top of stack, empty stack.
- `STACK_MIN`, 16'h0400: lowest legal stack address.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `op_valid`  in  1: request present.
- `op_code`  in  3: NONE=0, PUSH=1, POP=2, CALL=3, RET=4, INT=5, RTI=6, 7 reserved (treated as NONE).
- `op_ready`  out  1: sequencer idle; request accepted when `op_valid & op_ready`.
- `pc_in`  in  32: return PC for CALL/INT.
- `flags_in`  in  3: flag register for INT.
- `data_in`  in  16: operand for PUSH.
- `mem_addr`  out  16: memory address.
- `mem_read`, `mem_write`  out  1 each: memory strobes.
- `mem_wdata`  out  16: write data.
- `mem_rdata`  in  16: read data, valid the cycle after `mem_read`.
- `busy`  out  1: pipeline stall request, equal to `~op_ready`.
- `done`  out  1: one-cycle pulse when an operation completes.
- `stack_err`  out  1: one-cycle pulse, coincident with `done`, for a rejected operation.
- `pop_data`  out  16: POP result, valid while `done` is high.
- `pc_out`  out  32: popped PC, valid with `pc_load`.
- `pc_load`  out  1: pulse with `done` for RET/RTI.
- `flags_out`  out  3: popped flags, valid with `flags_load`.
- `flags_load`  out  1: pulse with `done` for RTI.
- `sp_out`  out  16: current SP.

## Operation
- Stack is full-descending.
  - Push word: write `M[SP]`, then SP ← SP−1.
  - Pop word: SP ← SP+1, then read `M[SP]`.
- Frame word counts and order:
  - PUSH: 1 word, `data_in`.
  - CALL: 2 words, `pc_in[31:16]` then `pc_in[15:0]`.
  - INT: 3 words, `{13'b0,flags_in}`, then PC hi, then PC lo.
  - POP: 1 word.
  - RET: 2 words, lo then hi.
  - RTI: 3 words, lo, hi, flags (`flags_out` = word[2:0]).
- Inputs are latched at acceptance. `pc_in`, `flags_in` and `data_in` are ignored afterward.
- Bounds are checked once, at acceptance:
  - Push of N words is legal iff SP ≥ STACK_MIN+N−1.
  - Pop of N words is legal iff SP+N ≤ SP_INIT.
  - An illegal operation enters ERR: no memory strobes, SP unchanged, `done` and `stack_err` pulse next cycle.
- FSM states: IDLE, PUSH, POP, CAPT, ERR, FIN.
  - IDLE → PUSH/POP/ERR on acceptance. NONE and reserved opcodes are not accepted.
  - PUSH: one write per cycle, word counter counts down; go to FIN after the last word.
  - POP: one read per cycle at address SP+1, SP updated the same edge. Each word is captured in the following cycle into a shift register. Go to CAPT after the last read.
  - CAPT: capture the final word, then go to FIN.
  - FIN and ERR: pulse `done` (plus `pc_load`/`flags_load`/`stack_err` as applicable), then return to IDLE.
- Strobes are never asserted outside PUSH/POP. `mem_read` and `mem_write` are never both high.
- SP arithmetic is 16-bit unsigned. Wrap-around cannot occur because of the bounds check.

## Timing
- Reset values:
  - state IDLE, SP=SP_INIT, `op_ready`=1.
  - All strobes and pulses 0.
  - `pop_data`, `pc_out`, `flags_out`, `mem_addr`, `mem_wdata` = 0.
- Acceptance at edge 0.
  - Push of N words: writes in cycles 1..N, `done` in cycle N+1, `busy` high for cycles 1..N+1.
  - Pop of N words: reads in cycles 1..N, capture in cycles 2..N+1, `done` in cycle N+2.
  - Error: `done`/`stack_err` in cycle 1.
- Latencies:
  - PUSH 2 cycles, CALL 3, INT 4.
  - POP 3, RET 4, RTI 5.
- `op_ready` rises in the cycle after `done`. There are no back-to-back accepts with zero gap.
- Reset mid-operation:
  - returns to IDLE next edge with SP=SP_INIT;
  - abandons the partial frame;
  - suppresses `done`.
- Reset asserted with `op_valid` high: the request is not accepted.

## Structure
- Shared package `stack_defs`:
  - op_code encodings;
  - FSM state encoding;
  - per-opcode frame word count and push/pop direction function.
- One natural sub-module `stack_pointer_unit`:
  - SP register, inc/dec, bounds-check comparators against SP_INIT/STACK_MIN;
  - outputs `can_push(N)` and `can_pop(N)`.
- FSM, word counter and capture shift register live in the top module.

## Test plan
- CALL, pc_in=32'h0001_0ABC, SP=07FF → writes M[07FF]=0001, M[07FE]=0ABC; SP=07FD; `done` in cycle 3.
- RET after the CALL above → reads 07FE, 07FF; `pc_out`=32'h0001_0ABC with `pc_load` in cycle 4; SP=07FF.
- INT (flags=3'b101, pc=32'h0000_0040), then RTI → flags word 0005 at 07FF; RTI returns `pc_out`=0040 and `flags_out`=101 in cycle 5; SP restored.
- POP on empty stack (SP=07FF) → no `mem_read`, `stack_err` and `done` in cycle 1; SP=07FF. PUSH at SP=0400 succeeds; CALL at SP=0400 is rejected.
- PUSH 16'hBEEF, then POP → `pop_data`=BEEF with `done` in cycle 3; `mem_read` and `mem_write` never both high.
- Reset asserted in cycle 2 of INT → next cycle: IDLE, SP=07FF, no `done`; a following PUSH behaves normally.

Source files
------------

// File: rtl/stack_defs.sv
// Shared definitions for the stack frame sequencer: opcodes, FSM states,
// and per-opcode frame shape.
package stack_defs;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_INT  = 3'd5,
    OP_RTI  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_CAPT,
    S_ERR,
    S_FIN
  } state_e;

  // Zero words marks an opcode that is never accepted.
  function automatic logic [1:0] frame_words(op_e op);
    case (op)
      OP_PUSH, OP_POP: return 2'd1;
      OP_CALL, OP_RET: return 2'd2;
      OP_INT,  OP_RTI: return 2'd3;
      default:         return 2'd0;
    endcase
  endfunction

  function automatic logic is_push(op_e op);
    return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

endpackage

// File: rtl/stack_frame_sequencer_if.sv
// Single-port data-memory bus driven by the stack frame sequencer.
interface stack_frame_sequencer_if;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (output mem_addr, mem_read, mem_write, mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, mem_read, mem_write, mem_wdata, output mem_rdata);
endinterface

// File: rtl/stack_pointer_unit.sv
// Stack pointer register with increment/decrement and bounds checks for an
// N-word push or pop starting from the current SP.
module stack_pointer_unit #(
  parameter logic [15:0] SP_INIT   = 16'h07FF,
  parameter logic [15:0] STACK_MIN = 16'h0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        dec,
  input  logic [1:0]  n,
  output logic [15:0] sp,
  output logic        can_push,
  output logic        can_pop
);

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset)    sp <= SP_INIT;
    else if (inc) sp <= sp + 16'd1;
    else if (dec) sp <= sp - 16'd1;
  end

  // 17-bit compares keep STACK_MIN+N-1 and SP+N from wrapping.
  assign can_push = {1'b0, sp} >= ({1'b0, STACK_MIN} + {15'b0, n} - 17'd1);
  assign can_pop  = ({1'b0, sp} + {15'b0, n}) <= {1'b0, SP_INIT};

endmodule

// File: rtl/stack_frame_sequencer.sv
// Sequences PUSH/POP/CALL/RET/INT/RTI frames as single-word accesses on the
// data-memory port, maintaining SP and stalling the pipeline while busy.
module stack_frame_sequencer
  import stack_defs::*;
#(
  parameter int          DATA_W    = 16,
  parameter logic [15:0] SP_INIT   = 16'h07FF,
  parameter logic [15:0] STACK_MIN = 16'h0400
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [2:0]            op_code,
  output logic                  op_ready,
  input  logic [31:0]           pc_in,
  input  logic [2:0]            flags_in,
  input  logic [DATA_W-1:0]     data_in,
  stack_frame_sequencer_if.master mem,
  output logic                  busy,
  output logic                  done,
  output logic                  stack_err,
  output logic [DATA_W-1:0]     pop_data,
  output logic [31:0]           pc_out,
  output logic                  pc_load,
  output logic [2:0]            flags_out,
  output logic                  flags_load,
  output logic [15:0]           sp_out
);

  state_e            state, state_n;
  op_e               op_in, op_q;
  logic [1:0]        cnt, n_in;
  logic              rd_q, accept, legal, can_push, can_pop;
  logic [15:0]       sp;
  logic [DATA_W-1:0] wbuf [3];
  logic [DATA_W-1:0] cap  [3];

  assign op_in  = op_e'(op_code);
  assign n_in   = frame_words(op_in);
  assign accept = op_valid && op_ready && (n_in != 2'd0);
  assign legal  = is_push(op_in) ? can_push : can_pop;

  stack_pointer_unit #(.SP_INIT(SP_INIT), .STACK_MIN(STACK_MIN)) u_sp (
    .clk      (clk),
    .reset    (reset),
    .inc      (state == S_POP),
    .dec      (state == S_PUSH),
    .n        (n_in),
    .sp       (sp),
    .can_push (can_push),
    .can_pop  (can_pop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= OP_NONE;
      cnt   <= 2'd0;
      rd_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        wbuf[i] <= '0;
        cap[i]  <= '0;
      end
    end else begin
      state <= state_n;
      rd_q  <= (state == S_POP);
      if (accept) begin
        op_q <= op_in;
        cnt  <= n_in;
        case (op_in)
          OP_PUSH: wbuf[0] <= data_in;
          OP_CALL: begin
            wbuf[0] <= pc_in[31:16];
            wbuf[1] <= pc_in[15:0];
          end
          OP_INT: begin
            wbuf[0] <= {13'b0, flags_in};
            wbuf[1] <= pc_in[31:16];
            wbuf[2] <= pc_in[15:0];
          end
          default: ;
        endcase
      end else if (state == S_PUSH || state == S_POP) begin
        cnt <= cnt - 2'd1;
      end
      // Write buffer drains from slot 0; one word per write cycle.
      if (state == S_PUSH) begin
        wbuf[0] <= wbuf[1];
        wbuf[1] <= wbuf[2];
        wbuf[2] <= '0;
      end
      // Read data arrives the cycle after each read and enters at the top.
      if (rd_q) begin
        cap[2] <= mem.mem_rdata;
        cap[1] <= cap[2];
        cap[0] <= cap[1];
      end
    end
  end

  // NOTE: every signal gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = !legal ? S_ERR : (is_push(op_in) ? S_PUSH : S_POP);
      S_PUSH: if (cnt == 2'd1) state_n = S_FIN;
      S_POP:  if (cnt == 2'd1) state_n = S_CAPT;
      S_CAPT: state_n = S_FIN;
      S_FIN:  state_n = S_IDLE;
      S_ERR:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_write = (state == S_PUSH);
    mem.mem_read  = (state == S_POP);
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    pop_data      = '0;
    pc_out        = '0;
    flags_out     = '0;
    if (state == S_PUSH) begin
      mem.mem_addr  = sp;
      mem.mem_wdata = wbuf[0];
    end else if (state == S_POP) begin
      mem.mem_addr  = sp + 16'd1;
    end
    if (state == S_FIN) begin
      if (op_q == OP_POP) pop_data = cap[2];
      if (op_q == OP_RET) pc_out = {cap[2], cap[1]};
      if (op_q == OP_RTI) begin
        pc_out    = {cap[1], cap[0]};
        flags_out = cap[2][2:0];
      end
    end
  end

  assign op_ready   = (state == S_IDLE);
  assign busy       = ~op_ready;
  assign done       = (state == S_FIN) || (state == S_ERR);
  assign stack_err  = (state == S_ERR);
  assign pc_load    = (state == S_FIN) && (op_q == OP_RET || op_q == OP_RTI);
  assign flags_load = (state == S_FIN) && (op_q == OP_RTI);
  assign sp_out     = sp;

endmodule

// File: tb/tb_stack_frame_sequencer.sv
// Scoreboard bench for stack_frame_sequencer: a reference stack model queues
// expected memory accesses and completions, compared as the DUT produces them.
module tb_stack_frame_sequencer;

  localparam logic [2:0] C_PUSH = 3'd1, C_POP = 3'd2, C_CALL = 3'd3,
                         C_RET  = 3'd4, C_INT = 3'd5, C_RTI  = 3'd6;

  typedef struct {
    logic        err;
    logic [2:0]  op;
    logic [15:0] pop_data;
    logic        pc_load;
    logic [31:0] pc;
    logic        flags_load;
    logic [2:0]  flags;
    int          lat;
    logic [15:0] sp;
  } done_t;

  logic        clk, reset, op_valid, op_ready, busy, done, stack_err;
  logic        pc_load, flags_load;
  logic [2:0]  op_code, flags_in, flags_out;
  logic [31:0] pc_in, pc_out;
  logic [15:0] data_in, pop_data, sp_out;

  stack_frame_sequencer_if mem_bus();

  stack_frame_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .pc_in(pc_in), .flags_in(flags_in), .data_in(data_in),
    .mem(mem_bus), .busy(busy), .done(done), .stack_err(stack_err),
    .pop_data(pop_data), .pc_out(pc_out), .pc_load(pc_load),
    .flags_out(flags_out), .flags_load(flags_load), .sp_out(sp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory environment: registered read data, valid the cycle after mem_read.
  logic [15:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_bus.mem_write) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    if (mem_bus.mem_read)  mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
  end

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_sp;
  logic [15:0] mdl [0:65535];
  logic [31:0] wq [$];
  logic [15:0] rq [$];
  done_t       cq [$];

  task automatic flush_model();
    exp_sp = 16'h07FF;
    wq.delete();
    rq.delete();
    cq.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    flush_model();
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] pc,
                       input logic [2:0] fl, input logic [15:0] d);
    done_t       e;
    int          n;
    bit          push, legal, got;
    logic [15:0] w [3];
    logic [15:0] v [3];
    logic [31:0] wexp;
    logic [15:0] rexp;
    n = 0; push = 0;
    w[0] = '0; w[1] = '0; w[2] = '0;
    case (op)
      C_PUSH: begin n = 1; push = 1; w[0] = d; end
      C_CALL: begin n = 2; push = 1; w[0] = pc[31:16]; w[1] = pc[15:0]; end
      C_INT:  begin n = 3; push = 1; w[0] = {13'b0, fl}; w[1] = pc[31:16]; w[2] = pc[15:0]; end
      C_POP:  n = 1;
      C_RET:  n = 2;
      C_RTI:  n = 3;
      default: n = 0;
    endcase
    e.err = 0; e.op = op; e.pop_data = '0; e.pc_load = 0; e.pc = '0;
    e.flags_load = 0; e.flags = '0;
    legal = push ? (int'(exp_sp) >= 32'h400 + n - 1) : (int'(exp_sp) + n <= 32'h7FF);
    if (!legal) begin
      e.err = 1;
      e.lat = 1;
    end else if (push) begin
      for (int i = 0; i < n; i++) begin
        wq.push_back({exp_sp, w[i]});
        mdl[exp_sp] = w[i];
        exp_sp = exp_sp - 16'd1;
      end
      e.lat = n + 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_sp = exp_sp + 16'd1;
        rq.push_back(exp_sp);
        v[i] = mdl[exp_sp];
      end
      e.lat = n + 2;
      if (op == C_POP) e.pop_data = v[0];
      if (op == C_RET || op == C_RTI) begin
        e.pc_load = 1;
        e.pc = {v[1], v[0]};
      end
      if (op == C_RTI) begin
        e.flags_load = 1;
        e.flags = v[2][2:0];
      end
    end
    e.sp = exp_sp;
    cq.push_back(e);

    @(negedge clk);
    op_valid = 1'b1; op_code = op; pc_in = pc; flags_in = fl; data_in = d;
    @(posedge clk);
    #1;
    op_valid = 1'b0; pc_in = $urandom; flags_in = 3'($urandom); data_in = 16'($urandom);
    got = 0;
    for (int cyc = 1; cyc <= 12 && !got; cyc++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy op=%0d cyc=%0d got=%b want=1", op, cyc, busy); end
      checks++;
      if (mem_bus.mem_read && mem_bus.mem_write) begin
        errors++; $display("FAIL strobe_overlap op=%0d cyc=%0d read=1 write=1 want not both", op, cyc);
      end
      if (mem_bus.mem_write === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          errors++; $display("FAIL unexpected_write op=%0d addr=%h data=%h", op, mem_bus.mem_addr, mem_bus.mem_wdata);
        end else begin
          wexp = wq.pop_front();
          if ({mem_bus.mem_addr, mem_bus.mem_wdata} !== wexp) begin
            errors++; $display("FAIL write op=%0d got=%h/%h want=%h/%h", op, mem_bus.mem_addr,
                               mem_bus.mem_wdata, wexp[31:16], wexp[15:0]);
          end
        end
      end
      if (mem_bus.mem_read === 1'b1) begin
        checks++;
        if (rq.size() == 0) begin
          errors++; $display("FAIL unexpected_read op=%0d addr=%h", op, mem_bus.mem_addr);
        end else begin
          rexp = rq.pop_front();
          if (mem_bus.mem_addr !== rexp) begin
            errors++; $display("FAIL read_addr op=%0d got=%h want=%h", op, mem_bus.mem_addr, rexp);
          end
        end
      end
      if (done === 1'b1) begin
        got = 1;
        e = cq.pop_front();
        checks++;
        if (cyc != e.lat) begin errors++; $display("FAIL latency op=%0d got=%0d want=%0d", op, cyc, e.lat); end
        checks++;
        if (stack_err !== e.err) begin errors++; $display("FAIL stack_err op=%0d got=%b want=%b", op, stack_err, e.err); end
        checks++;
        if ({pc_load, flags_load} !== {e.pc_load, e.flags_load}) begin
          errors++; $display("FAIL loads op=%0d got=%b%b want=%b%b", op, pc_load, flags_load, e.pc_load, e.flags_load);
        end
        checks++;
        if (sp_out !== e.sp) begin errors++; $display("FAIL sp op=%0d got=%h want=%h", op, sp_out, e.sp); end
        if (op == C_POP && !e.err) begin
          checks++;
          if (pop_data !== e.pop_data) begin errors++; $display("FAIL pop_data got=%h want=%h", pop_data, e.pop_data); end
        end
        if (e.pc_load) begin
          checks++;
          if (pc_out !== e.pc) begin errors++; $display("FAIL pc_out op=%0d got=%h want=%h", op, pc_out, e.pc); end
        end
        if (e.flags_load) begin
          checks++;
          if (flags_out !== e.flags) begin errors++; $display("FAIL flags_out got=%b want=%b", flags_out, e.flags); end
        end
      end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL done_timeout op=%0d got=no done want=done", op);
      void'(cq.pop_front());
    end
    @(negedge clk);
    checks++;
    if ({op_ready, done} !== 2'b10) begin
      errors++; $display("FAIL ready_after_done op=%0d got=%b%b want=10", op, op_ready, done);
    end
    checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      errors++; $display("FAIL missing_access op=%0d got=%0d/%0d left want=0/0", op, wq.size(), rq.size());
      wq.delete(); rq.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b1; op_code = C_PUSH; data_in = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({op_ready, mem_bus.mem_write, sp_out} !== {1'b1, 1'b0, 16'h07FF}) begin
      errors++; $display("FAIL reset_with_valid got=%b%b/%h want=10/07ff", op_ready, mem_bus.mem_write, sp_out);
    end
    reset = 1'b0; op_valid = 1'b0;
    flush_model();
    @(negedge clk);
    checks++;
    if ({busy, done, stack_err, pc_load, flags_load, mem_bus.mem_read, mem_bus.mem_write} !== 7'b0) begin
      errors++; $display("FAIL reset_pulses got=%b%b%b%b%b%b%b want=0000000", busy, done, stack_err,
                         pc_load, flags_load, mem_bus.mem_read, mem_bus.mem_write);
    end
    checks++;
    if ({mem_bus.mem_addr, mem_bus.mem_wdata, pop_data, pc_out, flags_out} !== 83'b0) begin
      errors++; $display("FAIL reset_values got=%h/%h/%h/%h/%b want=0", mem_bus.mem_addr,
                         mem_bus.mem_wdata, pop_data, pc_out, flags_out);
    end
    // NONE and reserved opcodes must not be accepted.
    for (int k = 0; k < 2; k++) begin
      op_valid = 1'b1; op_code = (k == 0) ? 3'd0 : 3'd7;
      @(negedge clk);
      checks++;
      if ({op_ready, mem_bus.mem_write, mem_bus.mem_read} !== 3'b100) begin
        errors++; $display("FAIL ignore_op%0d got=%b%b%b want=100", op_code, op_ready,
                           mem_bus.mem_write, mem_bus.mem_read);
      end
    end
    op_valid = 1'b0;
  endtask

  task automatic test_call_ret();
    do_op(C_CALL, 32'h0001_0ABC, 3'b000, 16'h0);
    checks++;
    if ({ram[16'h07FF], ram[16'h07FE]} !== 32'h0001_0ABC) begin
      errors++; $display("FAIL call_mem got=%h %h want=0001 0abc", ram[16'h07FF], ram[16'h07FE]);
    end
    do_op(C_RET, 32'h0, 3'b000, 16'h0);
  endtask

  task automatic test_int_rti();
    do_op(C_INT, 32'h0000_0040, 3'b101, 16'h0);
    checks++;
    if (ram[16'h07FF] !== 16'h0005) begin
      errors++; $display("FAIL int_flags_word got=%h want=0005", ram[16'h07FF]);
    end
    do_op(C_RTI, 32'h0, 3'b000, 16'h0);
  endtask

  task automatic test_push_pop();
    do_op(C_PUSH, 32'h0, 3'b000, 16'hBEEF);
    do_op(C_POP, 32'h0, 3'b000, 16'h0);
  endtask

  task automatic test_empty_pop();
    do_op(C_POP, 32'h0, 3'b000, 16'h0);
    do_op(C_RET, 32'h0, 3'b000, 16'h0);
  endtask

  task automatic test_bounds();
    for (int i = 0; i < 341; i++) do_op(C_INT, $urandom, 3'($urandom), 16'h0);
    checks++;
    if (sp_out !== 16'h0400) begin errors++; $display("FAIL bounds_sp got=%h want=0400", sp_out); end
    do_op(C_CALL, 32'h1234_5678, 3'b000, 16'h0);
    do_op(C_PUSH, 32'h0, 3'b000, 16'h1234);
    do_op(C_PUSH, 32'h0, 3'b000, 16'h5678);
    do_op(C_POP, 32'h0, 3'b000, 16'h0);
    do_op(C_RTI, 32'h0, 3'b000, 16'h0);
    apply_reset();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op_valid = 1'b1; op_code = C_INT; pc_in = 32'hDEAD_BEEF; flags_in = 3'b011;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({op_ready, done, sp_out} !== {1'b1, 1'b0, 16'h07FF}) begin
      errors++; $display("FAIL reset_mid got=%b%b/%h want=10/07ff", op_ready, done, sp_out);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, busy, mem_bus.mem_write} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_after got=%b%b%b want=000", done, busy, mem_bus.mem_write);
    end
    flush_model();
    do_op(C_PUSH, 32'h0, 3'b000, 16'hA5A5);
    do_op(C_POP, 32'h0, 3'b000, 16'h0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      do_op(op, $urandom, 3'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; op_code = '0; pc_in = '0; flags_in = '0; data_in = '0;
    flush_model();
    test_reset();
    test_call_ret();
    test_int_rti();
    test_push_pop();
    test_empty_pop();
    test_bounds();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
